// File: rtl/mmio_controller_ws.sv
// FPro MMIO controller with slot-targeted registered strobes,
// per-slot ready handshake, timeout and error reporting.
module mmio_controller_ws #(
    parameter int N_SLOTS = 64,
    parameter int SLOT_AW = 6,
    parameter int REG_AW  = 5,
    parameter int DW      = 32,
    parameter logic [N_SLOTS-1:0] SLOT_EN = '1,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mmio_cs,
    input  logic                     mmio_wr,
    input  logic                     mmio_rd,
    input  logic [20:0]              mmio_addr,
    input  logic [DW-1:0]            mmio_wr_data,
    output logic [DW-1:0]            mmio_rd_data,
    output logic                     mmio_ready,
    output logic                     mmio_err,
    output logic                     mmio_busy,
    output logic [15:0]              err_count,
    output logic [N_SLOTS-1:0]       slot_cs_array,
    output logic [N_SLOTS-1:0]       slot_mem_rd_array,
    output logic [N_SLOTS-1:0]       slot_mem_wr_array,
    output logic [REG_AW*N_SLOTS-1:0] slot_reg_addr_array,
    output logic [DW*N_SLOTS-1:0]    slot_wr_data_array,
    input  logic [DW*N_SLOTS-1:0]    slot_rd_data_array,
    input  logic [N_SLOTS-1:0]       slot_ready_array
);
    localparam int AW = REG_AW + SLOT_AW;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         state;
    logic [SLOT_AW-1:0] slot_q;
    logic [REG_AW-1:0]  reg_q;
    logic [DW-1:0]      wdata_q;
    logic               op_rd_q;
    logic               err_q;
    logic [CW-1:0]      cnt;

    logic [SLOT_AW-1:0] req_slot;
    logic [N_SLOTS-1:0] req_oh;
    logic               req;
    logic               mapped;
    logic               bad;
    logic               sel_ready;
    logic [DW-1:0]      sel_data;
    logic [CW-1:0]      cnt_inc;
    logic               unused_addr;

    assign req_slot    = mmio_addr[AW-1:REG_AW];
    assign unused_addr = ^mmio_addr[20:AW];
    assign req         = mmio_cs & (mmio_rd | mmio_wr);
    assign bad         = ~mapped | (mmio_rd & mmio_wr);
    assign cnt_inc     = cnt + 1'b1;

    // Slots beyond N_SLOTS never match, so they decode as unmapped
    always_comb begin
        mapped    = 1'b0;
        req_oh    = '0;
        sel_ready = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (req_slot == SLOT_AW'(i)) begin
                mapped    = SLOT_EN[i];
                req_oh[i] = 1'b1;
            end
            if (slot_q == SLOT_AW'(i)) begin
                sel_ready = slot_ready_array[i];
                sel_data  = slot_rd_data_array[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            slot_q            <= '0;
            reg_q             <= '0;
            wdata_q           <= '0;
            op_rd_q           <= 1'b0;
            err_q             <= 1'b0;
            cnt               <= '0;
            mmio_rd_data      <= '0;
            err_count         <= '0;
            slot_cs_array     <= '0;
            slot_mem_rd_array <= '0;
            slot_mem_wr_array <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        slot_q  <= req_slot;
                        reg_q   <= mmio_addr[REG_AW-1:0];
                        wdata_q <= mmio_wr_data;
                        op_rd_q <= mmio_rd;
                        cnt     <= '0;
                        if (bad) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err_q             <= 1'b0;
                            slot_cs_array     <= req_oh;
                            slot_mem_rd_array <= mmio_rd ? req_oh : '0;
                            slot_mem_wr_array <= mmio_wr ? req_oh : '0;
                            state             <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS, S_WAIT: begin
                    slot_cs_array     <= '0;
                    slot_mem_rd_array <= '0;
                    slot_mem_wr_array <= '0;
                    cnt               <= cnt_inc;
                    // A late ready on the final count still wins
                    if (sel_ready) begin
                        if (op_rd_q) mmio_rd_data <= sel_data;
                        err_q <= 1'b0;
                        state <= S_DONE;
                    end else if (cnt_inc == CW'(TIMEOUT)) begin
                        if (op_rd_q) mmio_rd_data <= '0;
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (err_q && err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                end
            endcase
        end
    end

    assign mmio_ready          = (state == S_DONE);
    assign mmio_err            = mmio_ready & err_q;
    assign mmio_busy           = (state != S_IDLE);
    assign slot_reg_addr_array = {N_SLOTS{reg_q}};
    assign slot_wr_data_array  = {N_SLOTS{wdata_q}};

endmodule

// File: tb/tb_mmio_controller_ws.sv
// Directed bench for mmio_controller_ws: read/write latency,
// timeout, immediate errors, busy, reset and saturation.
module tb_mmio_controller_ws;
    localparam int NS = 64;
    localparam int DW = 32;
    localparam int RA = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              mmio_cs;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [20:0]       mmio_addr;
    logic [DW-1:0]     mmio_wr_data;
    logic [DW-1:0]     mmio_rd_data;
    logic              mmio_ready;
    logic              mmio_err;
    logic              mmio_busy;
    logic [15:0]       err_count;
    logic [NS-1:0]     cs_arr;
    logic [NS-1:0]     rd_arr;
    logic [NS-1:0]     wr_arr;
    logic [RA*NS-1:0]  reg_arr;
    logic [DW*NS-1:0]  wd_arr;
    logic [DW*NS-1:0]  rdd_arr;
    logic [NS-1:0]     rdy_arr;

    int total = 0;
    int bad = 0;

    mmio_controller_ws #(
        .N_SLOTS(NS), .SLOT_AW(6), .REG_AW(RA), .DW(DW),
        .SLOT_EN(~(64'd1 << 40)), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready),
        .mmio_err(mmio_err), .mmio_busy(mmio_busy),
        .err_count(err_count),
        .slot_cs_array(cs_arr), .slot_mem_rd_array(rd_arr),
        .slot_mem_wr_array(wr_arr), .slot_reg_addr_array(reg_arr),
        .slot_wr_data_array(wd_arr), .slot_rd_data_array(rdd_arr),
        .slot_ready_array(rdy_arr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr,
                       input int slot, input int rg,
                       input logic [31:0] wd);
        mmio_cs      = 1'b1;
        mmio_rd      = rd;
        mmio_wr      = wr;
        mmio_addr    = 21'((slot << RA) | rg);
        mmio_wr_data = wd;
    endtask

    task automatic idle_bus();
        mmio_cs = 1'b0;
        mmio_rd = 1'b0;
        mmio_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        mmio_addr = '0;
        mmio_wr_data = '0;
        rdd_arr = '0;
        rdy_arr = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rdata", mmio_rd_data, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_busy", mmio_busy, 0);
        chk("rst_ready", mmio_ready, 0);
        chk("rst_cs", cs_arr, 0);

        // read slot 3 reg 5, ready in ACCESS
        req(1, 0, 3, 5, 0);
        tick();
        idle_bus();
        chk("rd_cs", cs_arr, 64'd1 << 3);
        chk("rd_rdstb", rd_arr, 64'd1 << 3);
        chk("rd_wrstb", wr_arr, 0);
        chk("rd_reg", reg_arr[3*RA +: RA], 5);
        rdy_arr[3] = 1'b1;
        rdd_arr[3*DW +: DW] = 32'hA5A5_0003;
        tick();
        rdy_arr[3] = 1'b0;
        chk("rd_ready", mmio_ready, 1);
        chk("rd_err", mmio_err, 0);
        chk("rd_data", mmio_rd_data, 32'hA5A5_0003);
        chk("rd_cs_off", cs_arr, 0);
        tick();
        chk("rd_ready_off", mmio_ready, 0);
        chk("rd_idle", mmio_busy, 0);

        // write slot 10 reg 31, ready after 4 WAIT cycles
        req(0, 1, 10, 31, 32'h1234_5678);
        tick();
        idle_bus();
        mmio_wr_data = 32'hDEAD_BEEF;
        chk("wr_wrstb", wr_arr, 64'd1 << 10);
        chk("wr_rdstb", rd_arr, 0);
        tick();
        chk("wr_stb_off", wr_arr, 0);
        chk("wr_data", wd_arr[10*DW +: DW], 32'h1234_5678);
        chk("wr_reg", reg_arr[10*RA +: RA], 31);
        tick();
        tick();
        tick();
        chk("wr_not_yet", mmio_ready, 0);
        rdy_arr[10] = 1'b1;
        tick();
        rdy_arr[10] = 1'b0;
        chk("wr_ready", mmio_ready, 1);
        chk("wr_err", mmio_err, 0);
        chk("wr_rdata_hold", mmio_rd_data, 32'hA5A5_0003);
        chk("wr_data_hold", wd_arr[0 +: DW], 32'h1234_5678);
        tick();

        // timeout on slot 7
        req(1, 0, 7, 0, 0);
        tick();
        idle_bus();
        repeat (14) tick();
        chk("to_not_yet", mmio_ready, 0);
        tick();
        chk("to_ready", mmio_ready, 1);
        chk("to_err", mmio_err, 1);
        chk("to_rdata", mmio_rd_data, 0);
        tick();
        chk("to_errcnt", err_count, 1);

        // ready on the final count wins
        rdd_arr[7*DW +: DW] = 32'h7777_0007;
        req(1, 0, 7, 0, 0);
        tick();
        idle_bus();
        repeat (14) tick();
        chk("late_not_yet", mmio_ready, 0);
        rdy_arr[7] = 1'b1;
        tick();
        rdy_arr[7] = 1'b0;
        chk("late_ready", mmio_ready, 1);
        chk("late_err", mmio_err, 0);
        chk("late_rdata", mmio_rd_data, 32'h7777_0007);
        tick();
        chk("late_errcnt", err_count, 1);

        // unmapped slot 40
        req(1, 0, 40, 0, 0);
        tick();
        idle_bus();
        chk("unm_ready", mmio_ready, 1);
        chk("unm_err", mmio_err, 1);
        chk("unm_cs", cs_arr, 0);
        chk("unm_rdstb", rd_arr, 0);
        tick();
        // rd and wr together on slot 2
        req(1, 1, 2, 0, 0);
        tick();
        idle_bus();
        chk("ill_ready", mmio_ready, 1);
        chk("ill_err", mmio_err, 1);
        chk("ill_stb", cs_arr | rd_arr | wr_arr, 0);
        chk("ill_rdata", mmio_rd_data, 32'h7777_0007);
        tick();
        chk("ill_errcnt", err_count, 3);

        // request during WAIT is dropped
        rdd_arr[5*DW +: DW] = 32'h5555_0005;
        req(1, 0, 5, 1, 0);
        tick();
        idle_bus();
        tick();
        req(0, 1, 6, 2, 32'hCAFE_0006);
        tick();
        idle_bus();
        chk("busy_no_stb", cs_arr | wr_arr, 0);
        chk("busy_reg", reg_arr[0 +: RA], 1);
        rdy_arr[5] = 1'b1;
        tick();
        rdy_arr[5] = 1'b0;
        chk("busy_ready", mmio_ready, 1);
        chk("busy_rdata", mmio_rd_data, 32'h5555_0005);
        tick();
        chk("busy_idle", mmio_busy, 0);
        tick();
        chk("busy_no_queue", mmio_busy, 0);

        // reset during WAIT
        req(1, 0, 5, 1, 0);
        tick();
        idle_bus();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy", mmio_busy, 0);
        chk("mrst_ready", mmio_ready, 0);
        chk("mrst_rdata", mmio_rd_data, 0);
        chk("mrst_errcnt", err_count, 0);
        chk("mrst_reg", reg_arr[5*RA +: RA], 0);
        tick();
        chk("mrst_no_ready", mmio_ready, 0);
        req(1, 0, 3, 5, 0);
        tick();
        idle_bus();
        rdy_arr[3] = 1'b1;
        tick();
        rdy_arr[3] = 1'b0;
        chk("post_ready", mmio_ready, 1);
        chk("post_rdata", mmio_rd_data, 32'hA5A5_0003);
        tick();

        // saturation: preload near the top, then push past it
        force dut.err_count = 16'hFFFD;
        tick();
        release dut.err_count;
        chk("sat_preload", err_count, 16'hFFFD);
        for (int i = 0; i < 4; i++) begin
            req(1, 1, 2, 0, 0);
            tick();
            idle_bus();
            tick();
        end
        chk("sat_errcnt", err_count, 16'hFFFF);
        req(1, 0, 40, 0, 0);
        tick();
        idle_bus();
        tick();
        chk("sat_hold", err_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
